// File: rtl/div16_8_seq.sv
// rtl/div16_8_seq.sv - sequential unsigned 16/8 restoring divider, one quotient bit per clock
// Macro DIV_APPROX_EN: compute only the 12 quotient MSBs; Q low nibble and R read as 0.
module div16_8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        DZ
);

`ifdef DIV_APPROX_EN
  localparam logic [4:0] N_ITER = 5'd12;
`else
  localparam logic [4:0] N_ITER = 5'd16;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dq_q, dq_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dzp_q, dzp_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        dz_q, dz_d;
  logic [8:0]  p_shift, p_diff;
  logic        q_bit;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign DZ        = dz_q;

  // P stays below B between iterations, so its 9th bit is always 0 and is not stored.
  // P' < 2B, so P' - B fits 9-bit two's complement and its sign bit is the borrow.
  assign p_shift = {p_q, dq_q[15]};
  assign p_diff  = p_shift - {1'b0, div_q};
  assign q_bit   = ~p_diff[8];

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    div_d   = div_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dzp_d   = dzp_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          dq_d    = A;
          div_d   = B;
          p_d     = 8'd0;
          cnt_d   = N_ITER;
          dzp_d   = (B == 8'd0);
        end
      end
      S_RUN: begin
        if (dzp_q) begin
          // Divide-by-zero spends one cycle here so out_valid rises one edge after acceptance.
          state_d = S_DONE;
          dzp_d   = 1'b0;
          q_d     = 16'hFFFF;
          r_d     = dq_q[7:0];
          dz_d    = 1'b1;
        end else begin
          // Dividend bits shift out the top while quotient bits shift in at the bottom.
          dq_d  = {dq_q[14:0], q_bit};
          p_d   = q_bit ? p_diff[7:0] : p_shift[7:0];
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = S_DONE;
            dz_d    = 1'b0;
`ifdef DIV_APPROX_EN
            q_d     = {dq_d[11:0], 4'b0000};
            r_d     = 8'd0;
`else
            q_d     = dq_d;
            r_d     = p_d;
`endif
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dq_q    <= 16'd0;
      div_q   <= 8'd0;
      p_q     <= 8'd0;
      cnt_q   <= 5'd0;
      dzp_q   <= 1'b0;
      q_q     <= 16'd0;
      r_q     <= 8'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dzp_q   <= dzp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_div16_8_seq.sv
// tb/tb_div16_8_seq.sv - randomized self-checking bench for div16_8_seq
module tb_div16_8_seq;

`ifdef DIV_APPROX_EN
  localparam int N_ITER = 12;
`else
  localparam int N_ITER = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        DZ;

  int n_tests;
  int n_fail;

  div16_8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .DZ        (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on the operands.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic dz);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q  = 16'hFFFF;
      r  = a[7:0];
      dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef DIV_APPROX_EN
      q  = 16'(((ai / 16) / bi) * 16);
      r  = 8'd0;
`else
      q  = 16'(ai / bi);
      r  = 8'(ai % bi);
`endif
    end
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold, input bit noise);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          lat;
    int          cyc;
    model(a, b, eq, er, ed);
    lat = ed ? 1 : N_ITER;
    out_ready = (hold == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom);
    B = 8'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        A = 16'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("out_valid", 32'(out_valid), 32'd1);
    check("Q", 32'(Q), 32'(eq));
    check("R", 32'(R), 32'(er));
    check("DZ", 32'(DZ), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        A = 16'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_Q", 32'(Q), 32'(eq));
      check("hold_R", 32'(R), 32'(er));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_Q_held", 32'(Q), 32'(eq));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          rh;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 16'd0;
    B         = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Q", 32'(Q), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_DZ", 32'(DZ), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_op(16'd50000, 8'd200, 0, 0);
    run_op(16'hFFFF,  8'd1,   0, 0);
    run_op(16'd1234,  8'd255, 0, 0);
    run_op(16'd5,     8'd7,   0, 0);
    run_op(16'h1234,  8'd0,   0, 0);
    run_op(16'd777,   8'd13,  10, 1);
    run_op(16'h1234,  8'd0,   3, 1);

    A = 16'd40000;
    B = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_Q", 32'(Q), 32'd0);
    check("midrun_rst_R", 32'(R), 32'd0);
    check("midrun_rst_DZ", 32'(DZ), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    run_op(16'd9, 8'd3, 0, 0);

    run_op(16'd50000, 8'd3,   0, 0);
    run_op(16'd0,     8'd255, 0, 0);
    run_op(16'hFFFF,  8'd255, 1, 0);

    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(ra, rb, rh, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
